onchip_mem_stream_loader: RTL and testbench
===========================================

Name: onchip_mem_stream_loader

Overview:
- Upstream feeder for the 32-bit, 4096-word single-port on-chip memory.
- Accepts a byte stream (e.g. from the UART receive path) over a valid/ready handshake.
- Packs bytes little-endian into 32-bit words and issues single-cycle word writes with byteenable to the memory's slave port.
- Controlled by a start/length command; reports busy, done, error and a write count.

Parameters:
- ADDR_W, 12, word address width of the target memory.
- DEPTH, 4096, number of 32-bit words in the target memory.
- LEN_W, 14, width of the byte-length command (max 16383 bytes).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first word address
- byte_len  in  LEN_W  number of bytes to load
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_ready  out  1  stream byte accepted when s_valid & s_ready
- mem_address  out  ADDR_W  memory word address
- mem_byteenable  out  4  lane enables
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  write data
- mem_clken  out  1  memory clock enable; constant 1
- busy  out  1  high from accepted start until the done pulse
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse alongside done when the range is invalid
- words_written  out  ADDR_W+1  words written by the current or last command
- crc  out  32  CRC of accepted bytes (see Optional Feature)

Behaviour:
- Reset values: all outputs 0 except mem_clken=1. State IDLE.
- States: IDLE, CHECK, COLLECT, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr and byte_len, clears words_written, sets busy, goes to CHECK.
  - start in any other state is ignored.
- CHECK (1 cycle):
  - nwords = ceil(byte_len/4), computed LEN_W+1 wide.
  - byte_len==0 -> DONE.
  - base_addr+nwords > DEPTH (computed ADDR_W+2 wide, no wrap) -> DONE with error.
  - Otherwise -> COLLECT.
- COLLECT:
  - s_ready=1.
  - Each accepted byte goes to lane = bytes_accepted mod 4; the lane's byteenable bit is set.
  - Go to WRITE when lane 3 is filled, or the last byte (count==byte_len) is accepted.
  - s_valid gaps stall without effect.
- WRITE (exactly 1 cycle):
  - s_ready=0; mem_chipselect=mem_write=1.
  - mem_address = current word address; writedata = packed word with unfilled lanes 0; byteenable = filled lanes.
  - Next cycle: address+1, words_written+1, lanes and byteenables cleared.
  - Returns to COLLECT if bytes remain, else DONE.
- DONE: done=1 for one cycle (error=1 with it if the range was rejected), busy=0 on the following cycle, -> IDLE.
- mem_chipselect and mem_write are high only in WRITE. No read is ever issued.
- Throughput: 4 bytes per 5 cycles at most; latency from last byte to done = 2 cycles.
- Reset mid-operation: the next cycle is IDLE, the partial word is discarded with no write, s_ready=0, busy=0, and no done pulse.

Optional Feature:
- Macro: LOADER_CRC_EN.
- With macro: CRC-32 over every accepted byte.
  - Reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Reinitialised at start; crc holds its result from the done pulse until the next start.
  - A rejected or zero-length command yields 0x00000000.
- Without macro: crc is tied to 32'h0 and no CRC logic is synthesised.

Decomposition:
- Package onchip_loader_pkg: state encoding, CRC32_POLY, CRC32_INIT, CRC32_XOROUT, NUM_LANES=4.
- Sub-module loader_crc32: registered byte-wise CRC engine with init/update/byte ports; instantiated only under LOADER_CRC_EN.

Test Plan:
- Aligned load: base 0x010, len 8, bytes 01..08 -> write 0x010=0x04030201 be 0xF, then 0x011=0x08070605 be 0xF; done=1; words_written=2; error=0.
- Partial tail with backpressure: base 0x100, len 5, bytes AA BB CC DD EE with idle gaps between bytes -> 0x100=0xDDCCBBAA be 0xF, then 0x101=0x000000EE be 0x1; no extra writes.
- Zero length: start with len 0 -> done 2 cycles after start; mem_chipselect never high; s_ready never high.
- Range check: base 0xFFF, len 5 -> error+done, no writes. Then base 0xFFF, len 4 -> single write at 0xFFF, error=0.
- Reset mid-COLLECT: after 2 of 8 bytes, pulse reset -> no memory write, busy=0, s_ready=0, done stays 0. A new start afterwards behaves normally.
- CRC (LOADER_CRC_EN): ASCII "123456789", base 0 -> crc=0xCBF43926 at the done pulse. Build without the macro -> crc=0.

Source files
------------

// File: rtl/onchip_loader_pkg.sv
// ---------------------------------------------------------------------------
// onchip_loader_pkg
// Shared definitions for the on-chip memory stream loader:
//   - loader_state_e : FSM state encoding
//   - NUM_LANES/LANE_W : byte lanes per 32-bit memory word
//   - CRC32_* constants and a byte-wise reflected CRC-32 step function
// ---------------------------------------------------------------------------
package onchip_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    // One byte through the reflected CRC-32 register (LSB-first shifting).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/loader_crc32.sv
// ---------------------------------------------------------------------------
// loader_crc32
// Registered byte-wise CRC-32 engine (reflected, poly 0xEDB88320).
// Only instantiated when LOADER_CRC_EN is defined.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   init         : reload the register with CRC32_INIT
//   update       : fold data_byte into the register this cycle
//   data_byte    : byte to fold in
//   crc_value    : current register with the final XOR applied
// ---------------------------------------------------------------------------
module loader_crc32
    import onchip_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        update,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_value
);

    logic [31:0] crc_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_state <= CRC32_INIT;
        end else if (init) begin
            crc_state <= CRC32_INIT;
        end else if (update) begin
            crc_state <= crc32_byte(crc_state, data_byte);
        end
    end

    assign crc_value = crc_state ^ CRC32_XOROUT;

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// ---------------------------------------------------------------------------
// onchip_mem_stream_loader
// Loads a byte stream into the 32-bit on-chip memory. Bytes are packed
// little-endian into words and written one word at a time with byteenables.
// Optional build macro: LOADER_CRC_EN (CRC-32 over accepted bytes on crc;
// without it crc is tied to zero and no CRC logic exists).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, base_addr, byte_len : command (sampled only in IDLE)
//   s_valid, s_data, s_ready   : byte stream handshake
//   mem_*                      : memory slave write port (mem_clken tied 1)
//   busy, done, error          : command status (done/error are pulses)
//   words_written              : words written by current/last command
//   crc                        : CRC-32 of the accepted bytes
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_CHECK   | one cycle: validate length and address range
// ST_COLLECT | s_ready high, packing bytes into the current word
// ST_WRITE   | one cycle: word write strobe on the memory port
// ST_DONE    | one cycle: done (and error if rejected), then IDLE
// ---------------------------------------------------------------------------
module onchip_mem_stream_loader
    import onchip_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int LEN_W  = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     byte_len,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [NUM_LANES-1:0] mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [31:0]          mem_writedata,
    output logic                 mem_clken,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W:0]      words_written,
    output logic [31:0]          crc
);

    localparam int SUM_W = ADDR_W + 2;

    loader_state_e        state;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     byte_cnt;
    logic [LEN_W-1:0]     cnt_next;
    logic [31:0]          lane_data;
    logic [31:0]          word_next;
    logic [NUM_LANES-1:0] lane_be;
    logic [NUM_LANES-1:0] be_next;
    logic [LANE_W-1:0]    lane;
    logic [LEN_W:0]       nwords;
    logic [SUM_W-1:0]     range_end;
    logic                 range_bad;
    logic                 last_lane;
    logic                 last_byte;
    logic                 byte_accept;

    // mem_address holds the latched base while in CHECK, so the range test
    // uses it directly. The sum is kept two bits wider than the address so
    // an end past the top of memory cannot wrap back into range.
    assign nwords    = ({1'b0, len_q} + (LEN_W+1)'(NUM_LANES - 1)) >> LANE_W;
    assign range_end = SUM_W'(mem_address) + SUM_W'(nwords);
    assign range_bad = range_end > SUM_W'(DEPTH);

    assign lane        = byte_cnt[LANE_W-1:0];
    assign cnt_next    = byte_cnt + LEN_W'(1);
    assign word_next   = lane_data | (32'(s_data) << {lane, 3'b000});
    assign be_next     = lane_be | (NUM_LANES'(1) << lane);
    assign last_lane   = (lane == LANE_W'(NUM_LANES - 1));
    assign last_byte   = (cnt_next == len_q);
    assign byte_accept = (state == ST_COLLECT) && s_valid && s_ready;

    assign mem_clken = 1'b1;

`ifdef LOADER_CRC_EN
    logic        crc_init;
    logic [31:0] crc_value;
    logic [31:0] crc_q;

    assign crc_init = (state == ST_IDLE) && start;

    loader_crc32 u_crc32 (
        .clk       (clk),
        .reset     (reset),
        .init      (crc_init),
        .update    (byte_accept),
        .data_byte (s_data),
        .crc_value (crc_value)
    );

    assign crc = crc_q;
`else
    assign crc = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            byte_cnt       <= '0;
            lane_data      <= '0;
            lane_be        <= '0;
            s_ready        <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_written  <= '0;
`ifdef LOADER_CRC_EN
            crc_q          <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mem_address   <= base_addr;
                        len_q         <= byte_len;
                        byte_cnt      <= '0;
                        lane_data     <= '0;
                        lane_be       <= '0;
                        words_written <= '0;
                        busy          <= 1'b1;
`ifdef LOADER_CRC_EN
                        crc_q         <= '0;
`endif
                        state         <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (len_q == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (range_bad) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (byte_accept) begin
                        byte_cnt <= cnt_next;
                        if (last_lane || last_byte) begin
                            s_ready        <= 1'b0;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_writedata  <= word_next;
                            mem_byteenable <= be_next;
                            lane_data      <= '0;
                            lane_be        <= '0;
                            state          <= ST_WRITE;
                        end else begin
                            lane_data <= word_next;
                            lane_be   <= be_next;
                        end
                    end
                end

                ST_WRITE: begin
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                    mem_writedata  <= '0;
                    mem_byteenable <= '0;
                    mem_address    <= mem_address + ADDR_W'(1);
                    words_written  <= words_written + (ADDR_W+1)'(1);
                    if (byte_cnt == len_q) begin
                        done  <= 1'b1;
`ifdef LOADER_CRC_EN
                        crc_q <= crc_value;
`endif
                        state <= ST_DONE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= ST_COLLECT;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
module tb_onchip_mem_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [13:0] byte_len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_written;
    logic [31:0] crc;

    always #5 clk = ~clk;

    onchip_mem_stream_loader #(.ADDR_W(12), .DEPTH(4096), .LEN_W(14)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .byte_len       (byte_len),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_written  (words_written),
        .crc            (crc)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        string       name;
        logic [11:0] base;
        logic [13:0] len;
        int          gap;
        bit          poke;
        int          pat_first;
        int          pat_step;
        bit          exp_err;
        int          exp_words;
        bit          lit;
        logic [31:0] lit_first;
        logic [31:0] lit_last;
        logic [3:0]  lit_last_be;
    } vec_t;

    // Bus monitor: everything the DUT does is recorded here, the driver only
    // takes snapshots and differences.
    wr_t         wr_q[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          cs_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_acc_cyc = 0;
    int          err_stray = 0;
    logic        err_at_done = 1'b0;
    logic [12:0] ww_at_done = '0;
    logic [31:0] crc_at_done = '0;

    always @(posedge clk) begin
        if (s_valid && s_ready) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
        if (mem_chipselect) begin
            cs_cnt <= cs_cnt + 1;
            if (mem_write) wr_q.push_back('{mem_address, mem_writedata, mem_byteenable});
        end
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            err_at_done <= error;
            ww_at_done  <= words_written;
            crc_at_done <= crc;
        end
        if (error && !done) err_stray <= err_stray + 1;
        cyc <= cyc + 1;
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] tx[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC-32: shift message bits in one at a time, LSB of each byte first.
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ tx[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    // Issue one command using the bytes in tx and check everything it did.
    task automatic run_cmd(input string name, input logic [11:0] base, input logic [13:0] len,
                           input int gap_pct, input bit poke, input bit exp_err, input int exp_words);
        int   wr0 = wr_q.size();
        int   acc0 = acc_cnt;
        int   cs0 = cs_cnt;
        int   dn0 = done_cnt;
        int   start_cyc;
        int   idx;
        int   budget;
        int   exp_bytes;
        int   n_act;
        bit   accepted;
        wr_t  exp_w[$];
        logic [31:0] exp_crc;

        exp_bytes = (exp_err || len == 0) ? 0 : int'(len);
        for (int w = 0; w * 4 < exp_bytes; w++) begin
            wr_t e;
            e.addr = base + 12'(w);
            e.data = '0;
            e.be   = '0;
            for (int j = 0; j < 4; j++) begin
                if (w * 4 + j < exp_bytes) begin
                    e.data[8*j +: 8] = tx[w*4+j];
                    e.be[j]          = 1'b1;
                end
            end
            exp_w.push_back(e);
        end
`ifdef LOADER_CRC_EN
        exp_crc = (exp_bytes == 0) ? 32'h0 : model_crc(exp_bytes);
`else
        exp_crc = 32'h0;
`endif

        base_addr = base;
        byte_len  = len;
        start     = 1'b1;
        s_valid   = 1'b0;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
        base_addr = 12'($urandom);
        byte_len  = 14'($urandom);
        check({name, " busy after start"}, 64'(busy), 64'd1);

        idx    = 0;
        budget = 0;
        while (idx < exp_bytes && budget < 20 * exp_bytes + 100) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? tx[idx] : 8'($urandom);
            if (poke) begin
                start     = ($urandom_range(3) == 0);
                base_addr = 12'($urandom);
                byte_len  = 14'($urandom);
            end
            accepted = s_valid && s_ready;
            tick();
            if (accepted) idx++;
            budget++;
        end
        start = 1'b0;
        check({name, " bytes fed"}, 64'(idx), 64'(exp_bytes));

        // Keep offering junk: nothing more may be accepted.
        s_valid = 1'b1;
        s_data  = 8'h5A;
        budget  = 0;
        while (done_cnt == dn0 && budget < 50) begin
            tick();
            budget++;
        end
        tick();
        tick();
        s_valid = 1'b0;

        n_act = wr_q.size() - wr0;
        check({name, " done pulses"},   64'(done_cnt - dn0), 64'd1);
        check({name, " error"},         64'(err_at_done), 64'(exp_err));
        check({name, " words_written"}, 64'(ww_at_done), 64'(exp_words));
        check({name, " bytes accepted"},64'(acc_cnt - acc0), 64'(exp_bytes));
        check({name, " chipselects"},   64'(cs_cnt - cs0), 64'(exp_w.size()));
        check({name, " writes"},        64'(n_act), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size(); k++) begin
            check($sformatf("%s write%0d", name, k),
                  (k < n_act) ? 64'(wr_q[wr0+k]) : 64'hx, 64'(exp_w[k]));
        end
        if (exp_bytes == 0)
            check({name, " done latency from start"}, 64'(done_cyc - start_cyc), 64'd2);
        else
            check({name, " done latency from last byte"}, 64'(done_cyc - last_acc_cyc), 64'd2);
        check({name, " busy after done"},   64'(busy), 64'd0);
        check({name, " s_ready after done"},64'(s_ready), 64'd0);
        check({name, " crc at done"},       64'(crc_at_done), 64'(exp_crc));
        check({name, " stray error"},       64'(err_stray), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];

    initial begin
        int          w0;
        int          acc0;
        int          cs0;
        int          dn0;
        int          budget;
        logic [11:0] rb;
        logic [13:0] rl;
        bit          rerr;
        int          rwords;
        string       s;

        vecs[0] = '{"aligned",    12'h010, 14'd8,     0,  0, 8'h01, 1,     0, 2,    1, 32'h04030201, 32'h08070605, 4'hF};
        vecs[1] = '{"tail_gaps",  12'h100, 14'd5,     60, 0, 8'hAA, 8'h11, 0, 2,    1, 32'hDDCCBBAA, 32'h000000EE, 4'h1};
        vecs[2] = '{"zero_len",   12'h200, 14'd0,     0,  0, -1,    0,     0, 0,    0, 32'h0, 32'h0, 4'h0};
        vecs[3] = '{"range_bad",  12'hFFF, 14'd5,     0,  0, -1,    0,     1, 0,    0, 32'h0, 32'h0, 4'h0};
        vecs[4] = '{"range_edge", 12'hFFF, 14'd4,     0,  0, -1,    0,     0, 1,    0, 32'h0, 32'h0, 4'h0};
        vecs[5] = '{"fit_top",    12'hFFE, 14'd8,     30, 1, -1,    0,     0, 2,    0, 32'h0, 32'h0, 4'h0};
        vecs[6] = '{"max_len_bad",12'h001, 14'd16381, 0,  0, -1,    0,     1, 0,    0, 32'h0, 32'h0, 4'h0};
        vecs[7] = '{"full_top",   12'hC00, 14'd4096,  10, 0, -1,    0,     0, 1024, 0, 32'h0, 32'h0, 4'h0};
        vecs[8] = '{"odd_poke",   12'h800, 14'd7,     50, 1, -1,    0,     0, 2,    0, 32'h0, 32'h0, 4'h0};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        byte_len  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        tick(); tick(); tick();
        check("reset busy",           64'(busy), 64'd0);
        check("reset done",           64'(done), 64'd0);
        check("reset error",          64'(error), 64'd0);
        check("reset s_ready",        64'(s_ready), 64'd0);
        check("reset chipselect",     64'(mem_chipselect), 64'd0);
        check("reset write",          64'(mem_write), 64'd0);
        check("reset address",        64'(mem_address), 64'd0);
        check("reset byteenable",     64'(mem_byteenable), 64'd0);
        check("reset writedata",      64'(mem_writedata), 64'd0);
        check("reset words_written",  64'(words_written), 64'd0);
        check("reset crc",            64'(crc), 64'd0);
        check("reset clken",          64'(mem_clken), 64'd1);
        reset = 1'b0;
        tick();

        // Table-driven commands.
        for (int v = 0; v < 9; v++) begin
            tx.delete();
            for (int i = 0; i < int'(vecs[v].len); i++)
                tx.push_back(vecs[v].pat_first >= 0 ? 8'(vecs[v].pat_first + i * vecs[v].pat_step)
                                                     : 8'($urandom));
            w0 = wr_q.size();
            run_cmd(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].gap, vecs[v].poke,
                    vecs[v].exp_err, vecs[v].exp_words);
            if (vecs[v].lit) begin
                check({vecs[v].name, " first word"},
                      (wr_q.size() > w0) ? 64'(wr_q[w0].data) : 64'hx, 64'(vecs[v].lit_first));
                check({vecs[v].name, " last word"},
                      (wr_q.size() > w0) ? 64'(wr_q[wr_q.size()-1].data) : 64'hx, 64'(vecs[v].lit_last));
                check({vecs[v].name, " last byteenable"},
                      (wr_q.size() > w0) ? 64'(wr_q[wr_q.size()-1].be) : 64'hx, 64'(vecs[v].lit_last_be));
            end
        end

        // Reset in the middle of collecting: two of eight bytes taken, then reset.
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        acc0 = acc_cnt;
        cs0  = cs_cnt;
        dn0  = done_cnt;
        base_addr = 12'h020;
        byte_len  = 14'd8;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        budget  = 0;
        while (acc_cnt - acc0 < 2 && budget < 20) begin
            s_data = tx[acc_cnt - acc0];
            tick();
            budget++;
        end
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        check("midreset busy",    64'(busy), 64'd0);
        check("midreset s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        s_valid = 1'b0;
        check("midreset bytes taken", 64'(acc_cnt - acc0), 64'd2);
        check("midreset no write",    64'(cs_cnt - cs0), 64'd0);
        check("midreset no done",     64'(done_cnt - dn0), 64'd0);
        run_cmd("after_reset", 12'h020, 14'd8, 20, 0, 0, 2);

        // CRC check value over ASCII "123456789".
        tx.delete();
        for (int i = 0; i < 9; i++) tx.push_back(8'(8'h31 + i));
        run_cmd("crc_ascii", 12'h000, 14'd9, 0, 0, 0, 3);
`ifdef LOADER_CRC_EN
        check("crc check value held", 64'(crc), 64'h00000000CBF43926);
`else
        check("crc tied off", 64'(crc), 64'h0);
`endif

        // Randomized commands against the arithmetic model.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(3) == 0) rb = 12'(4095 - $urandom_range(12));
            else                        rb = 12'($urandom_range(4095));
            rl = ($urandom_range(7) == 0) ? 14'd0 : 14'($urandom_range(1, 40));
            rerr   = (rl != 0) && (int'(rb) + (int'(rl) + 3) / 4 > 4096);
            rwords = (rerr || rl == 0) ? 0 : (int'(rl) + 3) / 4;
            tx.delete();
            for (int i = 0; i < int'(rl); i++) tx.push_back(8'($urandom));
            s = $sformatf("rand%0d", r);
            run_cmd(s, rb, rl, $urandom_range(70), bit'($urandom_range(1)), rerr, rwords);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
